ro_response_accumulator: RTL and testbench

Downstream consumer of the PUF StateMachine control strobes. Counts rising edges of the selected ring oscillator during each enable window and latches the count per loop on `store_response_puf`. Compares each loop pair (2k vs 2k+1) and accumulates majority votes across repetitions. On `done`, resolves one response bit per pair.

---
 rtl/ro_response_accumulator.sv | 159 +++++++++++++++
 tb/tb_ro_response_accumulator.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ro_response_accumulator.sv
// Counts selected ring-oscillator edges per enable window, compares loop pairs and
// accumulates majority votes across repetitions; resolves one response bit per pair on done.
module ro_response_accumulator #(
  parameter int NUM_LOOPS  = 4,
  parameter int COUNT_BITS = 16,
  parameter int VOTE_BITS  = 16,
  parameter int SEL_BITS   = $clog2(NUM_LOOPS-1)+1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [NUM_LOOPS-1:0]   ro_out,
  input  logic [SEL_BITS-1:0]    select_puf,
  input  logic                   reset_puf,
  input  logic                   enable_puf,
  input  logic                   store_response_puf,
  input  logic                   done,
  output logic [NUM_LOOPS/2-1:0] response,
  output logic                   response_valid,
  output logic                   busy
);

  localparam int PAIRS = NUM_LOOPS / 2;
  localparam int IDXW  = $clog2(NUM_LOOPS);

  typedef enum logic [1:0] {IDLE, COLLECT, RES_WAIT, RES_LOAD} state_t;

  state_t state, state_next;
  logic   load_resp;
  logic   done_q;

  logic [NUM_LOOPS-1:0]  sync1, sync2, prev;
  logic [IDXW-1:0]       sel_idx;
  logic                  sel_ok;
  logic                  sel_edge;
  logic [COUNT_BITS-1:0] cnt;
  logic [COUNT_BITS-1:0] cnt_reg [NUM_LOOPS];
  logic                  store_ok;
  logic                  pend;
  logic [IDXW-1:0]       pend_idx;
  logic [VOTE_BITS-1:0]  vote [PAIRS];
  logic [VOTE_BITS-1:0]  cmp  [PAIRS];
  logic [PAIRS-1:0]      resp_calc;

  assign sel_idx  = select_puf[IDXW-1:0];
  assign sel_ok   = 32'(select_puf) < NUM_LOOPS;
  assign sel_edge = sel_ok && sync2[sel_idx] && !prev[sel_idx];
  assign store_ok = store_response_puf && (state == COLLECT) && sel_ok && !start;
  assign busy     = (state != IDLE);

  // Two-flop synchronizer plus a third stage for rising-edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= ro_out;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (start || reset_puf) begin
      cnt <= '0;
    end else if (enable_puf && sel_edge && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Store latches the pre-increment count; an odd index arms the pair compare
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_LOOPS; i++) cnt_reg[i] <= '0;
      pend     <= 1'b0;
      pend_idx <= '0;
    end else if (start) begin
      for (int i = 0; i < NUM_LOOPS; i++) cnt_reg[i] <= '0;
      pend     <= 1'b0;
      pend_idx <= '0;
    end else begin
      pend <= store_ok && sel_idx[0];
      if (store_ok) begin
        cnt_reg[sel_idx] <= cnt;
        pend_idx         <= sel_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < PAIRS; k++) begin
        vote[k] <= '0;
        cmp[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < PAIRS; k++) begin
        if (start) begin
          vote[k] <= '0;
          cmp[k]  <= '0;
        end else if (pend && (32'(pend_idx) == 2*k+1)) begin
          if (cmp[k] != '1) cmp[k] <= cmp[k] + 1'b1;
          if ((cnt_reg[2*k] > cnt_reg[2*k+1]) && (vote[k] != '1)) vote[k] <= vote[k] + 1'b1;
        end
      end
    end
  end

  // Strict majority: ties and pairs never compared resolve to 0
  always_comb begin
    resp_calc = '0;
    for (int k = 0; k < PAIRS; k++) begin
      resp_calc[k] = {vote[k], 1'b0} > {1'b0, cmp[k]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      done_q <= 1'b0;
    end else begin
      state  <= state_next;
      done_q <= done;
    end
  end

  always_comb begin
    state_next = state;
    load_resp  = 1'b0;
    if (start) begin
      state_next = COLLECT;
    end else begin
      case (state)
        IDLE:     state_next = IDLE;
        COLLECT:  if (done && !done_q) state_next = RES_WAIT;
        RES_WAIT: state_next = RES_LOAD;
        RES_LOAD: begin
          load_resp  = 1'b1;
          state_next = IDLE;
        end
        default:  state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      response       <= '0;
      response_valid <= 1'b0;
    end else begin
      response_valid <= load_resp;
      if (load_resp) response <= resp_calc;
    end
  end

endmodule

// File: tb/tb_ro_response_accumulator.sv
// Scoreboard bench: a full-width DUT and a 4-bit-counter DUT share stimulus; a
// behavioural model pushes expected responses that are popped on response_valid.
module tb_ro_response_accumulator;

  localparam int NL = 4;
  localparam int SB = 3;

  logic          clk = 1'b0;
  logic          reset, start, reset_puf, enable_puf, store_response_puf, done;
  logic [NL-1:0] ro_out;
  logic [SB-1:0] select_puf;
  logic [1:0]    response, sat_response;
  logic          response_valid, sat_valid, busy, sat_busy;

  always #5 clk = ~clk;

  ro_response_accumulator u_dut (
    .clk(clk), .reset(reset), .start(start), .ro_out(ro_out), .select_puf(select_puf),
    .reset_puf(reset_puf), .enable_puf(enable_puf), .store_response_puf(store_response_puf),
    .done(done), .response(response), .response_valid(response_valid), .busy(busy)
  );

  ro_response_accumulator #(.COUNT_BITS(4)) u_sat (
    .clk(clk), .reset(reset), .start(start), .ro_out(ro_out), .select_puf(select_puf),
    .reset_puf(reset_puf), .enable_puf(enable_puf), .store_response_puf(store_response_puf),
    .done(done), .response(sat_response), .response_valid(sat_valid), .busy(sat_busy)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int pushes  = 0;
  int pulses  = 0;
  logic [3:0] sb_q [$];

  // index 0: 16-bit counter DUT, index 1: 4-bit counter DUT
  int m_cnt  [2][NL];
  int m_vote [2][NL/2];
  int m_cmp  [2][NL/2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void m_clear();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < NL; i++) m_cnt[d][i] = 0;
      for (int k = 0; k < NL/2; k++) begin
        m_vote[d][k] = 0;
        m_cmp[d][k]  = 0;
      end
    end
  endfunction

  function automatic void m_store(input int i, input int n);
    for (int d = 0; d < 2; d++) begin
      int lim;
      lim = (d == 1) ? 15 : 65535;
      m_cnt[d][i] = (n > lim) ? lim : n;
      if (i % 2 == 1) begin
        m_cmp[d][i/2]++;
        if (m_cnt[d][i-1] > m_cnt[d][i]) m_vote[d][i/2]++;
      end
    end
  endfunction

  function automatic logic [1:0] m_resp(input int d);
    logic [1:0] r;
    for (int k = 0; k < 2; k++) r[k] = (2*m_vote[d][k] > m_cmp[d][k]);
    return r;
  endfunction

  always @(negedge clk) begin
    if (response_valid) begin
      pulses++;
      if (sb_q.size() == 0) begin
        check("sb_unexpected_valid", 1, 0);
      end else begin
        logic [3:0] e;
        e = sb_q.pop_front();
        check("resp", response, e[1:0]);
        check("sat_resp", sat_response, e[3:2]);
        check("sat_valid", sat_valid, 1);
      end
    end
  end

  task automatic do_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    m_clear();
    check("busy_after_start", busy, 1);
  endtask

  task automatic run_loop(input int i, input int n, input bit hold_rst, input bit with_done);
    @(negedge clk) begin
      select_puf = SB'(i);
      reset_puf  = 1'b1;
    end
    @(negedge clk) begin
      reset_puf  = hold_rst;
      enable_puf = 1'b1;
    end
    repeat (n) begin
      ro_out[i] = 1'b1;
      repeat (2) @(negedge clk);
      ro_out[i] = 1'b0;
      repeat (2) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    enable_puf         = 1'b0;
    store_response_puf = 1'b1;
    if (with_done) done = 1'b1;
    m_store(i, hold_rst ? 0 : n);
    if (with_done) begin
      sb_q.push_back({m_resp(1), m_resp(0)});
      pushes++;
    end
    @(negedge clk) begin
      store_response_puf = 1'b0;
      reset_puf          = 1'b0;
    end
  endtask

  // Entered one negedge after the edge that samples done rising
  task automatic resolve_tail();
    check("valid_d0", response_valid, 0);
    @(negedge clk) check("valid_d1", response_valid, 0);
    @(negedge clk) check("valid_d2", response_valid, 1);
    check("busy_d2", busy, 0);
    @(negedge clk) check("valid_d3", response_valid, 0);
    done = 1'b0;
  endtask

  task automatic pass(input int c0, input int c1, input int c2, input int c3, input bit last);
    run_loop(0, c0, 1'b0, 1'b0);
    run_loop(1, c1, 1'b0, 1'b0);
    run_loop(2, c2, 1'b0, 1'b0);
    run_loop(3, c3, 1'b0, last);
    if (last) resolve_tail();
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; reset_puf = 1'b0; enable_puf = 1'b0;
    store_response_puf = 1'b0; done = 1'b0; ro_out = '0; select_puf = '0;
    m_clear();

    repeat (100) @(negedge clk);
    check("rst_resp", response, 0);
    check("rst_valid", response_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sat_resp", sat_response, 0);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk) done = 1'b1;
      repeat (3) @(negedge clk);
      done = 1'b0;
    end
    repeat (5) @(negedge clk);
    check("idle_resp", response, 0);
    check("idle_busy", busy, 0);
    check("idle_no_valid", pulses, 0);

    // single pass: 10>6 -> 1, 3>9 -> 0
    do_start();
    pass(10, 6, 3, 9, 1'b1);

    // majority over three repetitions: pair0 1,0,1  pair1 0,0,1
    do_start();
    pass(5, 2, 2, 4, 1'b0);
    pass(2, 5, 2, 4, 1'b0);
    pass(5, 2, 4, 2, 1'b1);

    // two repetitions 1,0 on both pairs -> ties
    do_start();
    pass(5, 2, 5, 2, 1'b0);
    pass(2, 5, 2, 5, 1'b1);

    // pair1's only compare comes from the store coinciding with done rising
    do_start();
    pass(2, 5, 5, 2, 1'b1);

    // 20 vs 17 edges: distinct at 16 bits, both saturate to 15 at 4 bits
    do_start();
    pass(20, 17, 1, 2, 1'b1);

    // restart mid-collect discards two passes that would otherwise win
    do_start();
    pass(5, 2, 5, 2, 1'b0);
    pass(5, 2, 5, 2, 1'b0);
    do_start();
    pass(2, 5, 2, 5, 1'b1);

    // reset_puf held through the window beats every edge
    do_start();
    run_loop(0, 5, 1'b1, 1'b0);
    run_loop(1, 2, 1'b0, 1'b0);
    run_loop(2, 4, 1'b0, 1'b0);
    run_loop(3, 1, 1'b0, 1'b1);
    resolve_tail();
    check("pre_ar_resp", response, 2'b10);

    // async reset while resolving
    do_start();
    pass(5, 2, 5, 2, 1'b0);
    @(negedge clk) done = 1'b1;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("ar_resp", response, 0);
    check("ar_valid", response_valid, 0);
    check("ar_busy", busy, 0);
    check("ar_sat_resp", sat_response, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    done  = 1'b0;
    repeat (6) @(negedge clk);
    check("ar_resp_after", response, 0);
    check("ar_busy_after", busy, 0);

    check("sb_empty", sb_q.size(), 0);
    check("valid_pulse_count", pulses, pushes);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
